hanoi_move_counter: RTL and testbench
=====================================

Name: hanoi_move_counter

Overview:
- Move-count register stage directly upstream of the four-digit decimal 7-segment decoder; its value output drives the decoder's 16-bit value input.
- Counts legal moves reported by the game FSM and supports undo.
- Holds a best-score record across games and debounces the raw clear key.
- After a win, alternates the displayed value between the current count and the best score.

Parameters:
- DEBOUNCE_CYCLES, 1000000: cycles the synchronised key must be stable low before a clear is accepted (20 ms at 50 MHz).
- MAX_COUNT, 9999: saturation limit, and reset value of best. Must be at most 9999 so the value fits four decimal digits.
- SHOW_CYCLES, 50000000: dwell cycles per display phase in the WON state.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- move_pulse  in  1  one-cycle pulse from game FSM: legal move made
- undo_pulse  in  1  one-cycle pulse: last move undone
- won_pulse  in  1  one-cycle pulse: puzzle solved
- key_clr_n  in  1  raw push-button, active-low, asynchronous to clk
- value  out  16  number to display (to decimal decoder)
- best  out  16  best (lowest) winning move count
- show_best  out  1  1 when value currently shows best
- overflow  out  1  sticky: a move was attempted at MAX_COUNT
- new_record  out  1  last win improved best
- state_o  out  2  00 IDLE, 01 PLAY, 10 WON

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, internal count 0, value 0, best MAX_COUNT, show_best 0, overflow 0, new_record 0, debounce and display timers 0.
- All outputs are registered. Every update becomes visible on value one cycle after the causing pulse edge.
- Key path:
  - key_clr_n passes through a 2-FF synchroniser.
  - The debounce counter resets on any change of the synchronised level.
  - When the level has been low for exactly DEBOUNCE_CYCLES consecutive cycles, a single one-cycle clr event is generated.
  - Holding the key produces no further events. A new event requires the key to be stable high for DEBOUNCE_CYCLES first.
- Priority within one cycle: clr > won_pulse > (move_pulse, undo_pulse).
- clr event, any state:
  - state IDLE, count 0, overflow 0, new_record 0, show_best 0, display timer 0.
  - best is retained; only rst_n reinitialises best.
- IDLE:
  - move_pulse: count 1, go to PLAY.
  - undo_pulse and won_pulse are ignored.
- PLAY:
  - move_pulse alone: if count < MAX_COUNT, count+1; else count stays at MAX_COUNT and overflow is set.
  - undo_pulse alone: count-1. If the result is 0, go to IDLE. undo never takes count below 0.
  - move_pulse and undo_pulse together: count unchanged, overflow unchanged.
  - won_pulse:
    - go to WON.
    - If count < best: best = count and new_record = 1; otherwise new_record = 0.
    - Display timer 0, show_best 0.
    - Any move/undo in the same cycle is dropped.
- WON:
  - move, undo and won pulses are ignored.
  - Display timer counts 0..SHOW_CYCLES-1 and wraps.
  - show_best toggles on each wrap: phase 0 shows count, phase 1 shows best.
- value mux: show_best ? best : count. In IDLE and PLAY, value = count.
- Arithmetic: 16-bit unsigned. count never exceeds MAX_COUNT. No wrap-around in either direction.

Test Plan (bench uses DEBOUNCE_CYCLES=4, SHOW_CYCLES=8):
- Reset, then 3 move_pulses -> value 1,2,3, each one cycle after its pulse; state_o 01. Then 1 undo_pulse -> value 2. Then 2 undo_pulses -> value 0, state_o 00.
- Preload count 9998 via moves (or force). 2 move_pulses -> value 9999, overflow 1. A third move -> value stays 9999.
- Play 7 moves, won_pulse -> best 7, new_record 1, state_o 10. value shows 7 for 8 cycles, then 7 (best) with show_best 1, toggling every 8 cycles. A move_pulse in WON -> no change.
- clr, then play 9 moves and win -> best stays 7, new_record 0. value alternates 9 / 7 every 8 cycles.
- Key bounce: key_clr_n low 3 cycles, high 1, then low 10 cycles -> exactly one clr event, about 6 cycles after the final fall. Count returns to 0; best preserved.
- Simultaneous events:
  - move_pulse+undo_pulse at count 5 -> count 5.
  - won_pulse+move_pulse at count 5 -> WON with count 5.
  - Assert rst_n low mid-WON -> all outputs return to reset values immediately; best returns to 9999.

Source files
------------

// File: rtl/hanoi_move_counter.sv
// ---------------------------------------------------------------------------
// hanoi_move_counter
//
// Move-count register stage that feeds the four-digit decimal 7-segment
// decoder. It counts legal moves reported by the game FSM, supports undo,
// remembers the best (lowest) winning move count across games and accepts a
// debounced clear key. After a win the displayed value alternates between the
// current count and the best score.
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   rst_n       asynchronous active-low reset
//   move_pulse  one-cycle pulse: legal move made
//   undo_pulse  one-cycle pulse: last move undone
//   won_pulse   one-cycle pulse: puzzle solved
//   key_clr_n   raw active-low clear push-button, asynchronous to clk
//   value       number to display (drives the decimal decoder)
//   best        best (lowest) winning move count
//   show_best   1 while value is showing best
//   overflow    sticky: a move was attempted at MAX_COUNT
//   new_record  the last win improved best
//   state_o     00 IDLE, 01 PLAY, 10 WON
// ---------------------------------------------------------------------------
module hanoi_move_counter #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned MAX_COUNT       = 9999,
    parameter int unsigned SHOW_CYCLES     = 50000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        move_pulse,
    input  logic        undo_pulse,
    input  logic        won_pulse,
    input  logic        key_clr_n,
    output logic [15:0] value,
    output logic [15:0] best,
    output logic        show_best,
    output logic        overflow,
    output logic        new_record,
    output logic [1:0]  state_o
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_PLAY = 2'b01;
    localparam logic [1:0] ST_WON  = 2'b10;

    localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned SHOW_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

    localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEBOUNCE_CYCLES);
    localparam logic [SHOW_W-1:0] SHOW_LAST = SHOW_W'(SHOW_CYCLES - 1);
    localparam logic [15:0]       MAX_VAL   = 16'(MAX_COUNT);

    // Synchroniser, debounce and registered clear event
    logic              key_s1_q, key_s1_d;
    logic              key_s2_q, key_s2_d;
    logic              deb_level_q, deb_level_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic              deb_armed_q, deb_armed_d;
    logic              clr_q, clr_d;

    // Game state and display registers
    logic [1:0]        state_q, state_d;
    logic [15:0]       count_q, count_d;
    logic [15:0]       best_q, best_d;
    logic              show_best_q, show_best_d;
    logic              overflow_q, overflow_d;
    logic              new_record_q, new_record_d;
    logic [SHOW_W-1:0] show_timer_q, show_timer_d;
    logic [15:0]       value_q, value_d;

    logic              level_changed;
    logic              deb_reached;

    // Key path. deb_cnt holds how many consecutive cycles the synchronised
    // level has been stable, saturating at DEBOUNCE_CYCLES. A clear fires only
    // on the cycle the low run first reaches the limit, and only when the
    // detector has been re-armed by a full-length stable-high run, so holding
    // the key or bouncing it never produces a second event.
    always_comb begin
        key_s1_d      = key_clr_n;
        key_s2_d      = key_s1_q;
        deb_level_d   = key_s2_q;
        level_changed = (key_s2_q != deb_level_q);

        if (level_changed) begin
            deb_cnt_d = DEB_W'(1);
        end else if (deb_cnt_q == DEB_MAX) begin
            deb_cnt_d = DEB_MAX;
        end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end

        deb_reached = (deb_cnt_d == DEB_MAX) && (level_changed || (deb_cnt_q != DEB_MAX));
        clr_d       = !key_s2_q && deb_reached && deb_armed_q;

        deb_armed_d = deb_armed_q;
        if (clr_d) begin
            deb_armed_d = 1'b0;
        end else if (key_s2_q && (deb_cnt_d == DEB_MAX)) begin
            deb_armed_d = 1'b1;
        end
    end

    // Game FSM. Clear beats win, win beats move/undo. The display value is
    // computed from the next-state values so every update shows up on value
    // exactly one cycle after the pulse that caused it.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        best_d       = best_q;
        show_best_d  = show_best_q;
        overflow_d   = overflow_q;
        new_record_d = new_record_q;
        show_timer_d = show_timer_q;

        if (clr_q) begin
            state_d      = ST_IDLE;
            count_d      = 16'd0;
            overflow_d   = 1'b0;
            new_record_d = 1'b0;
            show_best_d  = 1'b0;
            show_timer_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (move_pulse) begin
                        count_d = 16'd1;
                        state_d = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (won_pulse) begin
                        state_d      = ST_WON;
                        show_timer_d = '0;
                        show_best_d  = 1'b0;
                        if (count_q < best_q) begin
                            best_d       = count_q;
                            new_record_d = 1'b1;
                        end else begin
                            new_record_d = 1'b0;
                        end
                    end else if (move_pulse && !undo_pulse) begin
                        if (count_q < MAX_VAL) begin
                            count_d = count_q + 16'd1;
                        end else begin
                            count_d    = MAX_VAL;
                            overflow_d = 1'b1;
                        end
                    end else if (undo_pulse && !move_pulse) begin
                        // Guarded so a zero count can never wrap to 0xFFFF.
                        count_d = (count_q == 16'd0) ? 16'd0 : count_q - 16'd1;
                        if (count_q <= 16'd1) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_WON: begin
                    if (show_timer_q == SHOW_LAST) begin
                        show_timer_d = '0;
                        show_best_d  = !show_best_q;
                    end else begin
                        show_timer_d = show_timer_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        value_d = show_best_d ? best_d : count_d;
    end

    // All registers. The synchroniser resets to the released (high) level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1_q     <= 1'b1;
            key_s2_q     <= 1'b1;
            deb_level_q  <= 1'b1;
            deb_cnt_q    <= '0;
            deb_armed_q  <= 1'b0;
            clr_q        <= 1'b0;
            state_q      <= ST_IDLE;
            count_q      <= 16'd0;
            best_q       <= MAX_VAL;
            show_best_q  <= 1'b0;
            overflow_q   <= 1'b0;
            new_record_q <= 1'b0;
            show_timer_q <= '0;
            value_q      <= 16'd0;
        end else begin
            key_s1_q     <= key_s1_d;
            key_s2_q     <= key_s2_d;
            deb_level_q  <= deb_level_d;
            deb_cnt_q    <= deb_cnt_d;
            deb_armed_q  <= deb_armed_d;
            clr_q        <= clr_d;
            state_q      <= state_d;
            count_q      <= count_d;
            best_q       <= best_d;
            show_best_q  <= show_best_d;
            overflow_q   <= overflow_d;
            new_record_q <= new_record_d;
            show_timer_q <= show_timer_d;
            value_q      <= value_d;
        end
    end

    assign value      = value_q;
    assign best       = best_q;
    assign show_best  = show_best_q;
    assign overflow   = overflow_q;
    assign new_record = new_record_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_hanoi_move_counter.sv
// ---------------------------------------------------------------------------
// tb_hanoi_move_counter
//
// Self-checking bench for hanoi_move_counter with short debounce and display
// dwell times. A behavioural game model predicts every output on every cycle;
// directed literal checks along the way pin the model to hand-computed values.
// ---------------------------------------------------------------------------
module tb_hanoi_move_counter;

   localparam int DEB  = 4;
   localparam int MAXC = 9999;
   localparam int SHOW = 8;

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic        moveP = 1'b0;
   logic        undoP = 1'b0;
   logic        wonP = 1'b0;
   logic        keyClrN = 1'b1;
   logic [15:0] value;
   logic [15:0] best;
   logic        showBest;
   logic        overflow;
   logic        newRecord;
   logic [1:0]  stateO;

   int testsRun = 0;
   int testsFailed = 0;

   // Behavioural model state
   int mState = 0;
   int mCount = 0;
   int mBest = MAXC;
   int mOvf = 0;
   int mNr = 0;
   int mSince = 0;
   bit mKey1 = 1'b1;
   bit mKey2 = 1'b1;
   bit mPrevLevel = 1'b1;
   int mRunLen = 0;
   bit mArmed = 1'b0;
   bit mPendingClr = 1'b0;

   hanoi_move_counter #(
      .DEBOUNCE_CYCLES(DEB),
      .MAX_COUNT(MAXC),
      .SHOW_CYCLES(SHOW)
   ) dut (
      .clk(clk),
      .rst_n(rstN),
      .move_pulse(moveP),
      .undo_pulse(undoP),
      .won_pulse(wonP),
      .key_clr_n(keyClrN),
      .value(value),
      .best(best),
      .show_best(showBest),
      .overflow(overflow),
      .new_record(newRecord),
      .state_o(stateO)
   );

   // 10 ns clock; inputs change and outputs are sampled on the falling edge
   initial begin
      forever #5 clk = ~clk;
   end

   // One comparison with its own pass/fail bookkeeping
   task automatic checkOutput(input string name, input int actual, input int expected);
      testsRun++;
      if (actual != expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive one cycle of game pulses starting at a falling edge
   task automatic applyStimulus(input bit m, input bit u, input bit w);
      moveP = m;
      undoP = u;
      wonP  = w;
      @(negedge clk);
      moveP = 1'b0;
      undoP = 1'b0;
      wonP  = 1'b0;
   endtask

   // A clean key press long enough to clear, then a release long enough to re-arm
   task automatic pressKey();
      keyClrN = 1'b0;
      repeat (12) @(negedge clk);
      keyClrN = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   // Model, advanced on each rising edge. The key is seen through two
   // synchroniser stages; a low run of exactly DEB synchronised cycles after a
   // high run of at least DEB cycles yields one clear, which takes effect on
   // the game one edge later. The display phase is derived from the number of
   // edges elapsed since the win.
   initial begin
      bit clrNow;
      bit level;
      forever begin
         @(posedge clk or negedge rstN);
         if (!rstN) begin
            mState = 0; mCount = 0; mBest = MAXC; mOvf = 0; mNr = 0; mSince = 0;
            mKey1 = 1'b1; mKey2 = 1'b1; mPrevLevel = 1'b1; mRunLen = 0;
            mArmed = 1'b0; mPendingClr = 1'b0;
         end else begin
            clrNow = mPendingClr;
            mPendingClr = 1'b0;
            level = mKey2;
            mKey2 = mKey1;
            mKey1 = keyClrN;
            if (level == mPrevLevel) mRunLen++;
            else mRunLen = 1;
            mPrevLevel = level;
            if (!level && mRunLen == DEB && mArmed) begin
               mPendingClr = 1'b1;
               mArmed = 1'b0;
            end
            if (level && mRunLen >= DEB) mArmed = 1'b1;

            if (clrNow) begin
               mState = 0; mCount = 0; mOvf = 0; mNr = 0; mSince = 0;
            end else if (mState == 0) begin
               if (moveP) begin
                  mCount = 1;
                  mState = 1;
               end
            end else if (mState == 1) begin
               if (wonP) begin
                  mState = 2;
                  mSince = 0;
                  if (mCount < mBest) begin
                     mBest = mCount;
                     mNr = 1;
                  end else begin
                     mNr = 0;
                  end
               end else if (moveP && !undoP) begin
                  if (mCount < MAXC) mCount++;
                  else mOvf = 1;
               end else if (undoP && !moveP) begin
                  if (mCount > 0) mCount--;
                  if (mCount == 0) mState = 0;
               end
            end else begin
               mSince++;
            end
         end
      end
   end

   // Per-cycle comparison of every output against the model
   initial begin
      int mShow;
      forever begin
         @(negedge clk);
         mShow = (mState == 2 && ((mSince / SHOW) % 2) == 1) ? 1 : 0;
         checkOutput("model value", int'(value), (mShow != 0) ? mBest : mCount);
         checkOutput("model best", int'(best), mBest);
         checkOutput("model show_best", int'(showBest), mShow);
         checkOutput("model overflow", int'(overflow), mOvf);
         checkOutput("model new_record", int'(newRecord), mNr);
         checkOutput("model state", int'(stateO), mState);
      end
   end

   // Directed sequence with hand-computed expectations
   initial begin
      repeat (2) @(negedge clk);
      checkOutput("reset value", int'(value), 0);
      checkOutput("reset best", int'(best), 9999);
      checkOutput("reset state", int'(stateO), 0);
      checkOutput("reset overflow", int'(overflow), 0);
      checkOutput("reset show_best", int'(showBest), 0);
      checkOutput("reset new_record", int'(newRecord), 0);
      #2 rstN = 1'b1;
      @(negedge clk);
      repeat (6) @(negedge clk);

      // Moves and undo
      applyStimulus(1, 0, 0);
      checkOutput("move1 value", int'(value), 1);
      checkOutput("move1 state", int'(stateO), 1);
      applyStimulus(1, 0, 0);
      checkOutput("move2 value", int'(value), 2);
      applyStimulus(1, 0, 0);
      checkOutput("move3 value", int'(value), 3);
      applyStimulus(0, 1, 0);
      checkOutput("undo1 value", int'(value), 2);
      applyStimulus(0, 1, 0);
      applyStimulus(0, 1, 0);
      checkOutput("undo to zero value", int'(value), 0);
      checkOutput("undo to zero state", int'(stateO), 0);
      applyStimulus(0, 1, 0);
      checkOutput("idle undo value", int'(value), 0);
      applyStimulus(0, 0, 1);
      checkOutput("idle won state", int'(stateO), 0);

      // Saturation at MAX_COUNT
      repeat (9998) applyStimulus(1, 0, 0);
      checkOutput("preload value", int'(value), 9998);
      applyStimulus(1, 0, 0);
      checkOutput("at max value", int'(value), 9999);
      checkOutput("at max overflow", int'(overflow), 0);
      applyStimulus(1, 0, 0);
      checkOutput("over max value", int'(value), 9999);
      checkOutput("over max overflow", int'(overflow), 1);
      applyStimulus(1, 0, 0);
      checkOutput("still max value", int'(value), 9999);
      pressKey();
      checkOutput("clr value", int'(value), 0);
      checkOutput("clr overflow", int'(overflow), 0);
      checkOutput("clr state", int'(stateO), 0);

      // First win sets the record
      repeat (7) applyStimulus(1, 0, 0);
      applyStimulus(0, 0, 1);
      checkOutput("win1 value", int'(value), 7);
      checkOutput("win1 best", int'(best), 7);
      checkOutput("win1 new_record", int'(newRecord), 1);
      checkOutput("win1 state", int'(stateO), 2);
      repeat (7) @(negedge clk);
      checkOutput("win1 phase0 show_best", int'(showBest), 0);
      @(negedge clk);
      checkOutput("win1 phase1 show_best", int'(showBest), 1);
      checkOutput("win1 phase1 value", int'(value), 7);
      applyStimulus(1, 1, 1);
      checkOutput("won ignores pulses state", int'(stateO), 2);
      checkOutput("won ignores pulses value", int'(value), 7);

      // Second, worse win keeps the record
      pressKey();
      checkOutput("clr2 state", int'(stateO), 0);
      checkOutput("clr2 best kept", int'(best), 7);
      checkOutput("clr2 new_record", int'(newRecord), 0);
      repeat (9) applyStimulus(1, 0, 0);
      applyStimulus(0, 0, 1);
      checkOutput("win2 value", int'(value), 9);
      checkOutput("win2 best", int'(best), 7);
      checkOutput("win2 new_record", int'(newRecord), 0);
      repeat (8) @(negedge clk);
      checkOutput("win2 phase1 value", int'(value), 7);
      checkOutput("win2 phase1 show_best", int'(showBest), 1);
      repeat (8) @(negedge clk);
      checkOutput("win2 phase0 value", int'(value), 9);
      checkOutput("win2 phase0 show_best", int'(showBest), 0);

      // Bouncing key: short low, one high, then a long low gives one clear
      keyClrN = 1'b0;
      repeat (3) @(negedge clk);
      keyClrN = 1'b1;
      @(negedge clk);
      keyClrN = 1'b0;
      repeat (6) @(negedge clk);
      checkOutput("bounce before clr state", int'(stateO), 2);
      @(negedge clk);
      checkOutput("bounce clr state", int'(stateO), 0);
      checkOutput("bounce clr value", int'(value), 0);
      checkOutput("bounce clr best", int'(best), 7);
      repeat (3) @(negedge clk);
      keyClrN = 1'b1;
      repeat (8) @(negedge clk);
      checkOutput("bounce settled state", int'(stateO), 0);

      // Simultaneous pulses
      repeat (5) applyStimulus(1, 0, 0);
      checkOutput("five value", int'(value), 5);
      applyStimulus(1, 1, 0);
      checkOutput("move+undo value", int'(value), 5);
      checkOutput("move+undo state", int'(stateO), 1);
      applyStimulus(1, 0, 1);
      checkOutput("won+move state", int'(stateO), 2);
      checkOutput("won+move value", int'(value), 5);
      checkOutput("won+move best", int'(best), 5);
      checkOutput("won+move new_record", int'(newRecord), 1);

      // Asynchronous reset in the middle of WON
      repeat (3) @(negedge clk);
      #2 rstN = 1'b0;
      #1;
      checkOutput("async reset value", int'(value), 0);
      checkOutput("async reset best", int'(best), 9999);
      checkOutput("async reset state", int'(stateO), 0);
      checkOutput("async reset show_best", int'(showBest), 0);
      checkOutput("async reset new_record", int'(newRecord), 0);
      checkOutput("async reset overflow", int'(overflow), 0);
      @(negedge clk);
      #2 rstN = 1'b1;
      repeat (4) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
